// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: zero-wait hits, dirty-victim writeback, line refill
// and tag commit, sequenced one memory word per accepted transfer.
`ifndef CACHE_T
`define CACHE_T 20
`endif
`ifndef CACHE_S
`define CACHE_S 8
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_miss_ctrl #(
  parameter int TAG_WIDTH    = `CACHE_T,
  parameter int SET_WIDTH    = `CACHE_S,
  parameter int OFFSET_WIDTH = `CACHE_B
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cpu_req,
  input  logic                    cpu_wen,
  input  logic [31:0]             cpu_addr,
  output logic                    cpu_stall,
  input  logic                    hit,
  input  logic                    dirty,
  input  logic [TAG_WIDTH-1:0]    replace_tag,
  output logic                    lru_en,
  output logic [OFFSET_WIDTH-3:0] line_word,
  input  logic [31:0]             victim_rdata,
  output logic                    fill_wen,
  output logic [31:0]             fill_data,
  output logic                    fill_commit,
  output logic                    mem_req,
  output logic                    mem_wen,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready
);

  localparam int WW    = OFFSET_WIDTH - 2;
  localparam int WORDS = 2 ** WW;
  localparam logic [WW-1:0] LAST = WW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, COMMIT} state_t;

  state_t          state;
  logic [WW-1:0]   cnt;

  logic [TAG_WIDTH-1:0] cpu_tag;
  logic [SET_WIDTH-1:0] cpu_set;
  logic                 unused_bits;

  assign cpu_tag     = cpu_addr[31 -: TAG_WIDTH];
  assign cpu_set     = cpu_addr[OFFSET_WIDTH +: SET_WIDTH];
  assign unused_bits = ^{cpu_wen, cpu_addr[OFFSET_WIDTH-1:0]};

  // State and word counter; the counter returns to 0 at the end of each burst
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req && !hit) begin
            cnt   <= '0;
            state <= dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= REFILL;
            end else begin
              cnt <= cnt + WW'(1);
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= COMMIT;
            end else begin
              cnt <= cnt + WW'(1);
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output decode; reset masks everything except the stall echo of cpu_req
  always_comb begin
    cpu_stall   = 1'b0;
    lru_en      = 1'b0;
    line_word   = '0;
    fill_wen    = 1'b0;
    fill_data   = '0;
    fill_commit = 1'b0;
    mem_req     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (!reset_n) begin
      cpu_stall = cpu_req;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            cpu_stall = !hit;
            lru_en    = hit;
          end
        end
        WRITEBACK: begin
          cpu_stall = 1'b1;
          line_word = cnt;
          mem_req   = 1'b1;
          mem_wen   = 1'b1;
          mem_addr  = {replace_tag, cpu_set, cnt, 2'b00};
          mem_wdata = victim_rdata;
        end
        REFILL: begin
          cpu_stall = 1'b1;
          line_word = cnt;
          mem_req   = 1'b1;
          mem_addr  = {cpu_tag, cpu_set, cnt, 2'b00};
          fill_wen  = mem_ready;
          fill_data = mem_rdata;
        end
        COMMIT: begin
          cpu_stall   = 1'b1;
          fill_commit = 1'b1;
        end
        default: begin
          cpu_stall = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: directed and randomized hit/miss traffic checked
// against a transfer-list model of each miss.
module tb_cache_miss_ctrl;

  localparam int TW    = 20;
  localparam int SW    = 8;
  localparam int OW    = 4;
  localparam int WORDS = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_wen, cpu_stall;
  logic [31:0]   cpu_addr;
  logic          hit, dirty, lru_en;
  logic [TW-1:0] replace_tag;
  logic [OW-3:0] line_word;
  logic [31:0]   victim_rdata, fill_data, mem_addr, mem_wdata, mem_rdata;
  logic          fill_wen, fill_commit, mem_req, mem_wen, mem_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cache_miss_ctrl #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .OFFSET_WIDTH(OW)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_stall(cpu_stall), .hit(hit), .dirty(dirty),
    .replace_tag(replace_tag), .lru_en(lru_en), .line_word(line_word),
    .victim_rdata(victim_rdata), .fill_wen(fill_wen), .fill_data(fill_data),
    .fill_commit(fill_commit), .mem_req(mem_req), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Backing-memory content for a word address
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_quiet(input string tag, input logic stall_exp);
    check1({tag, "_stall"}, cpu_stall, stall_exp);
    check1({tag, "_lru"}, lru_en, 1'b0);
    check1({tag, "_mreq"}, mem_req, 1'b0);
    check1({tag, "_mwen"}, mem_wen, 1'b0);
    check({tag, "_maddr"}, mem_addr, 32'h0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    check1({tag, "_fwen"}, fill_wen, 1'b0);
    check({tag, "_fdata"}, fill_data, 32'h0);
    check1({tag, "_commit"}, fill_commit, 1'b0);
    check({tag, "_word"}, 32'(line_word), 32'h0);
  endtask

  task automatic idle_cycle();
    cpu_req = 1'b0; cpu_wen = 1'($urandom); cpu_addr = $urandom;
    hit = 1'($urandom); dirty = 1'($urandom); replace_tag = TW'($urandom);
    mem_ready = 1'($urandom); mem_rdata = $urandom; victim_rdata = $urandom;
    #1;
    check_quiet("idle", 1'b0);
    @(negedge clk);
  endtask

  task automatic hit_cycle(input logic [31:0] addr);
    cpu_req = 1'b1; cpu_wen = 1'($urandom); cpu_addr = addr; hit = 1'b1;
    dirty = 1'($urandom); mem_ready = 1'($urandom);
    #1;
    check1("hit_stall", cpu_stall, 1'b0);
    check1("hit_lru", lru_en, 1'b1);
    check1("hit_mreq", mem_req, 1'b0);
    check1("hit_fwen", fill_wen, 1'b0);
    check1("hit_commit", fill_commit, 1'b0);
    @(negedge clk);
  endtask

  // mode 0: random mem_ready, 1: always ready, 2: ready low 3 cycles on refill word 2
  // abort: drop reset while refill word 1 is outstanding
  task automatic run_miss(input logic [31:0] addr, input logic d, input logic [TW-1:0] rtag,
                          input int mode, input bit abort);
    logic [31:0] vline[WORDS];
    logic        wq[$];
    logic [31:0] aq[$];
    int          iq[$];
    logic [31:0] base_rd, base_wb, set_bits;
    int          budget, held;
    logic        rdy;

    for (int i = 0; i < WORDS; i++) vline[i] = $urandom;
    base_rd  = addr & ~((32'd1 << OW) - 32'd1);
    set_bits = (addr >> OW) & ((32'd1 << SW) - 32'd1);
    base_wb  = (32'(rtag) << (SW + OW)) | (set_bits << OW);
    if (d) begin
      for (int i = 0; i < WORDS; i++) begin
        wq.push_back(1'b1); aq.push_back(base_wb + 32'(i * 4)); iq.push_back(i);
      end
    end
    for (int i = 0; i < WORDS; i++) begin
      wq.push_back(1'b0); aq.push_back(base_rd + 32'(i * 4)); iq.push_back(i);
    end

    cpu_req = 1'b1; cpu_wen = 1'($urandom); cpu_addr = addr; hit = 1'b0;
    dirty = d; replace_tag = rtag; mem_ready = 1'($urandom);
    #1;
    check_quiet("miss", 1'b1);
    @(negedge clk);

    budget = 0;
    held   = 0;
    while (aq.size() > 0 && budget < 200) begin
      budget++;
      hit = 1'($urandom); dirty = 1'($urandom);
      case (mode)
        1: rdy = 1'b1;
        2: begin
          if (!wq[0] && iq[0] == 2 && held < 3) begin
            rdy = 1'b0; held++;
          end else begin
            rdy = 1'b1;
          end
        end
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      mem_ready    = rdy;
      mem_rdata    = rdy ? memword(aq[0]) : $urandom;
      victim_rdata = wq[0] ? vline[iq[0]] : $urandom;
      #1;
      check1("xfer_stall", cpu_stall, 1'b1);
      check1("xfer_mreq", mem_req, 1'b1);
      check1("xfer_mwen", mem_wen, wq[0]);
      check("xfer_maddr", mem_addr, aq[0]);
      check("xfer_word", 32'(line_word), 32'(iq[0]));
      check1("xfer_lru", lru_en, 1'b0);
      check1("xfer_commit", fill_commit, 1'b0);
      check1("xfer_fwen", fill_wen, rdy && !wq[0]);
      if (wq[0]) check("wb_wdata", mem_wdata, vline[iq[0]]);
      if (rdy && !wq[0]) check("fill_data", fill_data, memword(aq[0]));
      if (abort && !wq[0] && iq[0] == 1) begin
        #1 reset_n = 1'b0;
        #1;
        check_quiet("arst", 1'b1);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          mem_ready = 1'b1;
          #1;
          check_quiet("arst_hold", 1'b1);
        end
        cpu_req = 1'b0;
        #1;
        check_quiet("arst_noreq", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (rdy) begin
        void'(wq.pop_front()); void'(aq.pop_front()); void'(iq.pop_front());
      end
      @(negedge clk);
    end
    check("xfer_budget_left", 32'(aq.size()), 32'h0);

    hit = 1'($urandom); mem_ready = 1'($urandom);
    #1;
    check1("commit_pulse", fill_commit, 1'b1);
    check1("commit_stall", cpu_stall, 1'b1);
    check1("commit_mreq", mem_req, 1'b0);
    check1("commit_fwen", fill_wen, 1'b0);
    check1("commit_lru", lru_en, 1'b0);
    @(negedge clk);

    hit = 1'b1;
    #1;
    check1("post_stall", cpu_stall, 1'b0);
    check1("post_lru", lru_en, 1'b1);
    check1("post_commit", fill_commit, 1'b0);
    check1("post_mreq", mem_req, 1'b0);
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    reset_n = 1'b1; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; hit = 1'b0;
    dirty = 1'b0; replace_tag = '0; victim_rdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_quiet("rst", 1'b0);
    cpu_req = 1'b1; hit = 1'b1;
    #1;
    check_quiet("rst_req", 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    cpu_req = 1'b0;

    idle_cycle();
    idle_cycle();
    hit_cycle($urandom);
    hit_cycle($urandom);

    // clean miss, memory always ready
    run_miss(32'hABCDE_540, 1'b0, TW'($urandom), 1, 1'b0);
    idle_cycle();
    // dirty miss, victim tag 0x12 in set 3
    a = {20'h3C3C3, 8'd3, 4'h8};
    run_miss(a, 1'b1, 20'h00012, 1, 1'b0);
    idle_cycle();
    // refill word 2 held off for three cycles
    run_miss(32'h1234_5670, 1'b0, TW'($urandom), 2, 1'b0);
    idle_cycle();
    // reset mid-refill, then the same access restarts from word 0
    a = 32'h0F0F_0A30;
    run_miss(a, 1'b0, TW'($urandom), 1, 1'b1);
    idle_cycle();
    run_miss(a, 1'b0, TW'($urandom), 1, 1'b0);
    idle_cycle();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: idle_cycle();
        1: hit_cycle($urandom);
        default: run_miss($urandom, 1'($urandom), TW'($urandom), 0, 1'b0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
